signed_seq_divider: RTL and testbench

//  Sequential signed integer divider, the inverse datapath of the Booth multiplier.

---
 rtl/signed_seq_divider.sv | 171 +++++++++++++++++
 tb/tb_signed_seq_divider.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/signed_seq_divider.sv
// signed_seq_divider
//   Sequential signed integer divider. Restoring division on operand
//   magnitudes, one quotient bit per cycle, followed by a sign-fix cycle
//   that registers the signed results and the exception flags.
//
// Ports
//   i_clk          rising-edge clock
//   i_rst          synchronous, active-high reset
//   i_start        request, sampled only while idle
//   i_dividend     signed dividend, captured on the accepted start edge
//   i_divisor      signed divisor, captured on the accepted start edge
//   o_busy         high in every state except IDLE
//   o_done         one-cycle pulse; results valid from this cycle on
//   o_quotient     signed quotient, truncated toward zero
//   o_remainder    signed remainder, sign follows the dividend
//   o_overflow     set for MIN / -1
//   o_div_by_zero  set when the divisor was zero
module signed_seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_overflow,
    output logic             o_div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // Magnitudes never exceed 2^(WIDTH-1), so WIDTH bits hold them exactly
    // (including |MIN|); the (WIDTH+1)-bit partial remainder exists only as
    // the shifted working value a_sh, since a settled remainder is below D.
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             ovf_q, ovf_d;
    logic             dbz_flag_q, dbz_flag_d;

    logic [WIDTH:0]   a_sh;
    logic [WIDTH-1:0] dn_mag;
    logic [WIDTH-1:0] dv_mag;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        q_d        = q_q;
        d_d        = d_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        dbz_d      = dbz_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        ovf_d      = ovf_q;
        dbz_flag_d = dbz_flag_q;

        a_sh   = {a_q, q_q[WIDTH-1]};
        dn_mag = i_dividend[WIDTH-1] ? -i_dividend : i_dividend;
        dv_mag = i_divisor[WIDTH-1]  ? -i_divisor  : i_divisor;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    neg_quo_d = i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
                    neg_rem_d = i_dividend[WIDTH-1];
                    q_d       = dn_mag;
                    d_d       = dv_mag;
                    a_d       = '0;
                    cnt_d     = CW'(WIDTH);
                    dbz_d     = (i_divisor == '0);
                    state_d   = (i_divisor == '0) ? S_FIX : S_ITER;
                end
            end
            S_ITER: begin
                if (a_sh >= {1'b0, d_q}) begin
                    a_d = a_sh[WIDTH-1:0] - d_q;
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    a_d = a_sh[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (dbz_q) begin
                    // ITER was skipped, so Q still holds |dividend| and the
                    // dividend is rebuilt from it with the saved sign.
                    quo_d      = '1;
                    rem_d      = neg_rem_q ? -q_q : q_q;
                    ovf_d      = 1'b0;
                    dbz_flag_d = 1'b1;
                end else begin
                    quo_d      = neg_quo_q ? -q_q : q_q;
                    rem_d      = neg_rem_q ? -a_q : a_q;
                    // A positive quotient with the top bit set only arises
                    // from MIN / -1; the raw magnitude already wraps to MIN.
                    ovf_d      = ~neg_quo_q & q_q[WIDTH-1];
                    dbz_flag_d = 1'b0;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            a_q        <= '0;
            q_q        <= '0;
            d_q        <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dbz_q      <= 1'b0;
            quo_q      <= '0;
            rem_q      <= '0;
            ovf_q      <= 1'b0;
            dbz_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            q_q        <= q_d;
            d_q        <= d_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            dbz_q      <= dbz_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            ovf_q      <= ovf_d;
            dbz_flag_q <= dbz_flag_d;
        end
    end

    assign o_busy        = (state_q != S_IDLE);
    assign o_done        = (state_q == S_DONE);
    assign o_quotient    = quo_q;
    assign o_remainder   = rem_q;
    assign o_overflow    = ovf_q;
    assign o_div_by_zero = dbz_flag_q;

endmodule

// File: tb/tb_signed_seq_divider.sv
// tb_signed_seq_divider
//   Scoreboard bench for signed_seq_divider (WIDTH=4). The driver pushes the
//   expected result of every request that should complete; a monitor pops and
//   compares on each o_done, including the start-to-done latency.
module tb_signed_seq_divider;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dn;
    logic [W-1:0] dv;
    logic         busy;
    logic         done;
    logic [W-1:0] quo;
    logic [W-1:0] rem;
    logic         ovf;
    logic         dbz;

    signed_seq_divider #(.WIDTH(W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_dividend   (dn),
        .i_divisor    (dv),
        .o_busy       (busy),
        .o_done       (done),
        .o_quotient   (quo),
        .o_remainder  (rem),
        .o_overflow   (ovf),
        .o_div_by_zero(dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         ovf;
        logic         dbz;
        int           start_cyc;
        int           lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    function automatic int sx(logic [W-1:0] v);
        return v[W-1] ? int'(v) - (1 << W) : int'(v);
    endfunction

    // Reference: plain signed integer arithmetic (truncating / and %).
    function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, int sc);
        exp_t e;
        int x;
        int y;
        int qi;
        int ri;
        x = sx(a);
        y = sx(b);
        e.start_cyc = sc;
        e.ovf = 1'b0;
        e.dbz = 1'b0;
        if (y == 0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
            e.lat = 2;
        end else begin
            e.lat = W + 2;
            if (x == -(1 << (W - 1)) && y == -1) begin
                e.q   = a;
                e.r   = '0;
                e.ovf = 1'b1;
            end else begin
                qi  = x / y;
                ri  = x % y;
                e.q = qi[W-1:0];
                e.r = ri[W-1:0];
            end
        end
        return e;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("quotient", quo, mon_e.q);
                check("remainder", rem, mon_e.r);
                check("overflow", ovf, mon_e.ovf);
                check("div_by_zero", dbz, mon_e.dbz);
                check("latency", cyc - mon_e.start_cyc, mon_e.lat);
            end
        end
    end

    // Called #1 after a rising edge with the DUT idle.
    task automatic issue(logic [W-1:0] a, logic [W-1:0] b);
        dn    = a;
        dv    = b;
        start = 1'b1;
        sb.push_back(model(a, b, cyc));
        @(posedge clk); #1;
        start = 1'b0;
        dn    = W'($urandom_range(0, 15));
        dv    = W'($urandom_range(0, 15));
        check("busy_after_start", busy, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_within_budget", busy, 0);
    endtask

    task automatic run(logic [W-1:0] a, logic [W-1:0] b);
        issue(a, b);
        wait_idle();
    endtask

    task automatic check_cleared(string tag);
        check({tag, "_quotient"}, quo, 0);
        check({tag, "_remainder"}, rem, 0);
        check({tag, "_overflow"}, ovf, 0);
        check({tag, "_div_by_zero"}, dbz, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        dn    = '0;
        dv    = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_cleared("reset");

        // Directed cases, issued back-to-back.
        run(4'd7, 4'd2);
        run(4'b1001, 4'd2);
        run(4'd7, 4'b1110);
        run(4'b1000, 4'd3);
        run(4'b1000, 4'b1111);
        run(4'd6, 4'd3);
        run(4'd5, 4'd0);

        // Results hold while idle.
        repeat (5) @(posedge clk);
        #1;
        check("hold_quotient", quo, 4'hF);
        check("hold_remainder", rem, 4'h5);
        check("hold_div_by_zero", dbz, 1);

        // A start pulse mid-operation must be ignored.
        issue(4'd7, 4'd2);
        repeat (2) begin
            @(posedge clk); #1;
        end
        dn    = 4'd1;
        dv    = 4'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();
        repeat (3) @(posedge clk);
        #1;

        // Reset mid-operation: aborted request produces no done.
        dn    = 4'd7;
        dv    = 4'd2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_cleared("abort");
        repeat (10) @(posedge clk);
        #1;
        run(4'd6, 4'b1100);

        // Randomized operands.
        for (int i = 0; i < 200; i++) begin
            run(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
